digital_pll_controller_v2: RTL

DIGITAL_PLL_CONTROLLER_V2 -- requirements
Module: digital_pll_controller_v2

---
 rtl/digital_pll_controller_v2.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/digital_pll_controller_v2.sv
// -----------------------------------------------------------------------------
// digital_pll_controller_v2
//
// Purpose: closed-loop trim controller for a digitally controlled oscillator.
// The DCO-derived clock counts its own cycles across each period of a slower
// asynchronous reference (osc). Each measured period is compared with the
// target div; the binary trim value tval is stepped toward the target and a
// lock indicator tracks consecutive in-tolerance measurements.
//
// Ports:
//   clock      in   DCO-derived clock (sole clock)
//   resetb     in   synchronous active-low reset
//   enable     in   1 = controller active
//   dco        in   1 = external-trim mode, controller idles
//   osc        in   reference clock, asynchronous to clock
//   hold       in   1 = freeze tval, measuring and lock tracking continue
//   div        in   target clock cycles per osc period
//   trim       out  registered thermometer code of tval (one cycle behind)
//   tval       out  binary trim value, 0..TRIM_W
//   meas       out  last measured period in clock cycles
//   meas_valid out  one-cycle pulse when meas updates
//   locked     out  high while LOCK_N consecutive measurements were in tolerance
// -----------------------------------------------------------------------------
module digital_pll_controller_v2 #(
    parameter int DIV_W     = 5,
    parameter int TRIM_W    = 26,
    parameter int CNT_W     = DIV_W + 2,
    parameter int LOCK_TOL  = 1,
    parameter int LOCK_N    = 4,
    parameter int STEP2_THR = 4,
    parameter int TRIM_INIT = 0
) (
    input  logic                            clock,
    input  logic                            resetb,
    input  logic                            enable,
    input  logic                            dco,
    input  logic                            osc,
    input  logic                            hold,
    input  logic [DIV_W-1:0]                div,
    output logic [TRIM_W-1:0]               trim,
    output logic [$clog2(TRIM_W+1)-1:0]     tval,
    output logic [CNT_W-1:0]                meas,
    output logic                            meas_valid,
    output logic                            locked
);

    localparam int TV_W = $clog2(TRIM_W + 1);
    localparam int LC_W = $clog2(LOCK_N + 1);
    localparam int EW   = CNT_W + 1;

    // Thermometer encoding: bit i set iff i < v.
    function automatic logic [TRIM_W-1:0] therm(input logic [TV_W-1:0] v);
        logic [TRIM_W-1:0] t;
        for (int i = 0; i < TRIM_W; i++) begin
            t[i] = (i < int'(v));
        end
        return t;
    endfunction

    logic                   osc_s1_r, osc_s2_r, osc_dly_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   first_seen_r;
    logic [LC_W-1:0]        lock_cnt_r;
    logic [TV_W-1:0]        tval_r;
    logic [TRIM_W-1:0]      trim_r;
    logic [CNT_W-1:0]       meas_r;
    logic                   meas_valid_r;
    logic                   locked_r;

    logic                   edge_s;
    logic                   active_s;
    logic signed [EW-1:0]   err_s;
    logic [EW-1:0]          err_abs_s;
    logic                   in_tol_s;
    logic [TV_W:0]          step_s;
    logic [TV_W:0]          up_sum_s;
    logic [TV_W-1:0]        tval_up_s;
    logic [TV_W-1:0]        tval_dn_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic [LC_W-1:0]        lock_inc_s;

    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   seen_nxt_s;
    logic [LC_W-1:0]        lock_nxt_s;
    logic [TV_W-1:0]        tval_nxt_s;
    logic [CNT_W-1:0]       meas_nxt_s;
    logic                   mv_nxt_s;

    // Rising edge of the synchronised reference, one cycle wide.
    assign edge_s   = osc_s2_r & ~osc_dly_r;
    assign active_s = enable & ~dco;

    // Error is taken against the counter value at the edge, which is the
    // period just completed; div is zero-extended into the signed width.
    assign err_s     = $signed({1'b0, cnt_r}) - $signed({{(EW-DIV_W){1'b0}}, div});
    assign err_abs_s = err_s[EW-1] ? $unsigned(-err_s) : $unsigned(err_s);
    assign in_tol_s  = (err_abs_s <= EW'(LOCK_TOL));
    assign step_s    = (err_abs_s > EW'(STEP2_THR)) ? (TV_W+1)'(2) : (TV_W+1)'(1);

    // Saturating trim arithmetic: clamp at TRIM_W on the way up, 0 on the way down.
    assign up_sum_s  = {1'b0, tval_r} + step_s;
    assign tval_up_s = (up_sum_s > (TV_W+1)'(TRIM_W)) ? TV_W'(TRIM_W) : up_sum_s[TV_W-1:0];
    assign tval_dn_s = ({1'b0, tval_r} < step_s) ? {TV_W{1'b0}}
                                                 : TV_W'({1'b0, tval_r} - step_s);

    assign cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    assign lock_inc_s = (lock_cnt_r == LC_W'(LOCK_N)) ? lock_cnt_r : lock_cnt_r + LC_W'(1);

    // Next-state: period counter, first-edge flag, measurement, trim and lock count.
    always_comb begin
        cnt_nxt_s  = cnt_inc_s;
        seen_nxt_s = first_seen_r;
        lock_nxt_s = lock_cnt_r;
        tval_nxt_s = tval_r;
        meas_nxt_s = meas_r;
        mv_nxt_s   = 1'b0;
        if (!active_s) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            seen_nxt_s = 1'b0;
            lock_nxt_s = {LC_W{1'b0}};
        end else if (edge_s) begin
            cnt_nxt_s  = CNT_W'(1);
            seen_nxt_s = 1'b1;
            if (first_seen_r) begin
                meas_nxt_s = cnt_r;
                mv_nxt_s   = 1'b1;
                if (div == {DIV_W{1'b0}}) begin
                    // No meaningful target: report only, never trim or lock.
                    lock_nxt_s = {LC_W{1'b0}};
                end else if (in_tol_s) begin
                    lock_nxt_s = lock_inc_s;
                end else begin
                    lock_nxt_s = {LC_W{1'b0}};
                    if (hold) begin
                        tval_nxt_s = tval_r;
                    end else if (!err_s[EW-1]) begin
                        tval_nxt_s = tval_up_s;
                    end else begin
                        tval_nxt_s = tval_dn_s;
                    end
                end
            end else begin
                // First edge after reset or idle only arms the measurement.
                meas_nxt_s = meas_r;
            end
        end else begin
            cnt_nxt_s = cnt_inc_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            osc_s1_r     <= 1'b0;
            osc_s2_r     <= 1'b0;
            osc_dly_r    <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            first_seen_r <= 1'b0;
            lock_cnt_r   <= {LC_W{1'b0}};
            tval_r       <= TV_W'(TRIM_INIT);
            trim_r       <= therm(TV_W'(TRIM_INIT));
            meas_r       <= {CNT_W{1'b0}};
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            osc_s1_r     <= osc;
            osc_s2_r     <= osc_s1_r;
            osc_dly_r    <= osc_s2_r;
            cnt_r        <= cnt_nxt_s;
            first_seen_r <= seen_nxt_s;
            lock_cnt_r   <= lock_nxt_s;
            tval_r       <= tval_nxt_s;
            trim_r       <= therm(tval_r);
            meas_r       <= meas_nxt_s;
            meas_valid_r <= mv_nxt_s;
            locked_r     <= (lock_nxt_s == LC_W'(LOCK_N));
        end
    end

    assign trim       = trim_r;
    assign tval       = tval_r;
    assign meas       = meas_r;
    assign meas_valid = meas_valid_r;
    assign locked     = locked_r;

endmodule
